taxi_state_ctrl: RTL

//  Trip-state sequencer for the taxi controller. Drives the 2-bit state bus that the timer and

---
 rtl/taxi_state_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/taxi_state_ctrl.sv
// taxi_state_ctrl: trip-state sequencer with stall timeout, seconds tick and trip counter
module taxi_state_ctrl #(
  parameter int STALL_TICKS = 200,
  parameter int TICK_DIV    = 100,
  parameter int TRIP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              wheel_pulse,
  output logic [1:0]        state,
  output logic              sec_tick,
  output logic              trip_done,
  output logic [TRIP_W-1:0] trip_cnt
);
  localparam int SW = $clog2(STALL_TICKS);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TICKS - 1);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, MOVE = 2'b01, WAIT = 2'b11} st_t;
  st_t st;
  logic [2:0] s1, s2, prev;
  logic [SW-1:0] stall_cnt;
  logic [PW-1:0] prescale;
  logic start_e, stop_e, wheel_e, wrap, stall;
  assign {wheel_e, stop_e, start_e} = s2 & ~prev;
  assign wrap = prescale == TICK_MAX;
  assign stall = stall_cnt == STALL_MAX;
  assign state = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      stall_cnt <= '0;
      prescale  <= '0;
      sec_tick  <= 1'b0;
      trip_done <= 1'b0;
      trip_cnt  <= '0;
    end else begin
      s1        <= {wheel_pulse, btn_stop, btn_start};
      s2        <= s1;
      prev      <= s2;
      trip_done <= 1'b0;
      sec_tick  <= 1'b0;
      prescale  <= '0;
      case (st)
        IDLE: if (start_e) begin
          st        <= MOVE;
          stall_cnt <= '0;
        end
        MOVE, WAIT: if (stop_e) begin
          st        <= IDLE;
          trip_done <= 1'b1;
          trip_cnt  <= &trip_cnt ? trip_cnt : trip_cnt + 1'b1;
        end else begin
          // prescale runs unbroken through MOVE<->WAIT so the tick phase is preserved
          prescale <= wrap ? '0 : prescale + 1'b1;
          sec_tick <= wrap;
          if (wheel_e) begin
            st        <= MOVE;
            stall_cnt <= '0;
          end else if (st == MOVE) begin
            st        <= stall ? WAIT : MOVE;
            stall_cnt <= stall ? '0 : stall_cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
